cacheline_adaptor: RTL

- Responder on the cache's line-granular physical-memory port; the cache controller issues pmem_read/pmem_write, this block answers with a single-cycle resp.
- Initiator on the burst main-memory port: converts one LINE_W transfer into BEATS = LINE_W/BURST_W consecutive BURST_W beats.
- Sits between cache datapath/control and the burst memory model.

---
 rtl/cache_types_pkg.sv | 22 ++
 rtl/line_beat_buffer.sv | 34 +++
 rtl/cacheline_adaptor.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/cache_types_pkg.sv
// Shared widths, line/beat types and the adaptor state encoding for the
// cache-to-burst-memory adaptor.
package cache_types_pkg;

   localparam int unsigned LINE_W     = 256;
   localparam int unsigned BURST_W    = 64;
   localparam int unsigned BEATS      = LINE_W / BURST_W;
   localparam int unsigned OFFSET_W   = $clog2(LINE_W / 8);
   localparam int unsigned BEAT_IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef logic [LINE_W-1:0]     line_t;
   typedef logic [BURST_W-1:0]    beat_t;
   typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

   typedef enum logic [1:0] {
      StIdle,
      StRdBurst,
      StWrBurst,
      StDone
   } adaptor_state_e;

endpackage

// File: rtl/line_beat_buffer.sv
// One cache line of storage, viewed as BEATS beats: full-line load,
// beat-indexed write and beat-indexed read. Load wins over beat write.
module line_beat_buffer
   import cache_types_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      load_en,
   input  line_t     load_line,
   input  logic      wr_en,
   input  beat_idx_t wr_idx,
   input  beat_t     wr_beat,
   input  beat_idx_t rd_idx,
   output beat_t     rd_beat,
   output line_t     line
);

   logic [BEATS-1:0][BURST_W-1:0] line_q;

   // Line storage: whole-line load or a single beat update.
   always_ff @(posedge clk) begin
      if (rst) begin
         line_q <= '0;
      end else if (load_en) begin
         line_q <= load_line;
      end else if (wr_en) begin
         line_q[wr_idx] <= wr_beat;
      end
   end

   assign rd_beat = line_q[rd_idx];
   assign line    = line_q;

endmodule

// File: rtl/cacheline_adaptor.sv
// Bridges the cache's line-wide pmem port to a BURST_W-wide burst memory.
// One line transfer becomes BEATS beats; completion is a one-cycle pmem_resp.
// Optional watchdog abort enabled by defining CACHELINE_ADAPTOR_TIMEOUT_EN.
module cacheline_adaptor
   import cache_types_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pmem_address,
   input  logic              pmem_read,
   input  logic              pmem_write,
   input  logic [LINE_W-1:0] pmem_wdata,
   output logic [LINE_W-1:0] pmem_rdata,
   output logic              pmem_resp,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   output logic              mem_write,
   output logic [BURST_W-1:0] mem_wdata,
   input  logic [BURST_W-1:0] mem_rdata,
   input  logic              mem_resp,
   output logic              err
);

   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((LINE_W / 8) - 1);

   adaptor_state_e    state_q, state_d;
   beat_idx_t         beat_q, beat_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              is_rd_q, is_rd_d;
   line_t             rdata_q;
   line_t             buf_line;
   line_t             buf_load_line;
   beat_t             buf_beat;
   logic              buf_load;
   logic              buf_wr;
   logic              last_beat;
   logic              timeout;

   assign last_beat = (beat_q == beat_idx_t'(BEATS - 1));

   // Writes stage the line here; reads assemble beats here (cleared at accept
   // so an aborted read exposes only the beats actually received).
   line_beat_buffer u_buf (
      .clk      (clk),
      .rst      (rst),
      .load_en  (buf_load),
      .load_line(buf_load_line),
      .wr_en    (buf_wr),
      .wr_idx   (beat_q),
      .wr_beat  (mem_rdata),
      .rd_idx   (beat_q),
      .rd_beat  (buf_beat),
      .line     (buf_line)
   );

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
   localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic              err_q;
   logic              busy;

   assign busy = (state_q == StRdBurst) || (state_q == StWrBurst);

   // Count burst cycles without a beat strobe; any strobe restarts the window.
   always_comb begin
      wdog_d  = '0;
      timeout = 1'b0;
      if (busy && !mem_resp) begin
         wdog_d  = wdog_q + WDOG_W'(1);
         timeout = (wdog_d == WDOG_W'(TIMEOUT_CYCLES));
      end
   end

   // Watchdog counter and sticky error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wdog_q <= wdog_d;
         if (timeout) begin
            err_q <= 1'b1;
         end
      end
   end

   assign err = err_q;
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   // Next-state logic: accept in idle, count beats, complete through done.
   always_comb begin
      state_d       = state_q;
      beat_d        = beat_q;
      addr_d        = addr_q;
      is_rd_d       = is_rd_q;
      buf_load      = 1'b0;
      buf_load_line = '0;
      buf_wr        = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Write has priority if both requests are (illegally) raised.
            if (pmem_write || pmem_read) begin
               addr_d        = pmem_address & LINE_MASK;
               beat_d        = '0;
               is_rd_d       = !pmem_write;
               buf_load      = 1'b1;
               buf_load_line = pmem_write ? pmem_wdata : '0;
               state_d       = pmem_write ? StWrBurst : StRdBurst;
            end
         end
         StRdBurst: begin
            if (mem_resp) begin
               buf_wr = 1'b1;
               if (last_beat) begin
                  state_d = StDone;
               end else begin
                  beat_d = beat_q + beat_idx_t'(1);
               end
            end else if (timeout) begin
               state_d = StDone;
            end
         end
         StWrBurst: begin
            if (mem_resp) begin
               if (last_beat) begin
                  state_d = StDone;
               end else begin
                  beat_d = beat_q + beat_idx_t'(1);
               end
            end else if (timeout) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         beat_q  <= '0;
         addr_q  <= '0;
         is_rd_q <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         addr_q  <= addr_d;
         is_rd_q <= is_rd_d;
      end
   end

   // Completed read line, held across later writes until the next read ends.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (state_q == StDone && is_rd_q) begin
         rdata_q <= buf_line;
      end
   end

   assign mem_address = addr_q;
   assign mem_read    = (state_q == StRdBurst);
   assign mem_write   = (state_q == StWrBurst);
   assign mem_wdata   = mem_write ? buf_beat : '0;
   assign pmem_resp   = (state_q == StDone);
   // During the done cycle of a read the fresh line bypasses the hold register.
   assign pmem_rdata  = (pmem_resp && is_rd_q) ? buf_line : rdata_q;

endmodule
